// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// branch flush generation and registered forwarding selection.
//
// Optional feature: define ID_EX_PERF_EN to build saturating 16-bit stall and
// flush performance counters. Without it the counter ports are tied to zero
// and no counter flops exist.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_* controls/data/fields        decode-stage instruction fields
//   id_rs_src, id_rt_src             decode instruction reads rs / rt
//   id_PCWre                         branch taken in ID
//   mem_wr_reg, mem_targReg          MEM-stage write enable / destination
//   wb_wr_reg, wb_targReg, write_data  register-file write-back port
//   ex_*                             registered EX-stage copies of id_*
//   ex_fwdA, ex_fwdB                 operand source select (00 rf, 01 EX/MEM,
//                                    10 MEM/WB, 11 ex_wb_bypass)
//   ex_wb_bypass                     last captured write-back data
//   stall, ifid_flush                combinational hazard controls
//   stall_cnt, flush_cnt             performance counters
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_if_wr_reg,
    input  logic        id_isLW,
    input  logic        id_ALUSrcB,
    input  logic        id_ALUM2Reg,
    input  logic        id_DataMemRW,
    input  logic [2:0]  id_ALUOp,
    input  logic [31:0] id_readData1,
    input  logic [31:0] id_readData2,
    input  logic [31:0] id_immediate_32,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_targReg,
    input  logic        id_rs_src,
    input  logic        id_rt_src,
    input  logic        id_PCWre,
    input  logic        mem_wr_reg,
    input  logic [4:0]  mem_targReg,
    input  logic        wb_wr_reg,
    input  logic [4:0]  wb_targReg,
    input  logic [31:0] write_data,
    output logic        ex_if_wr_reg,
    output logic        ex_isLW,
    output logic        ex_ALUSrcB,
    output logic        ex_ALUM2Reg,
    output logic        ex_DataMemRW,
    output logic [2:0]  ex_ALUOp,
    output logic [31:0] ex_readData1,
    output logic [31:0] ex_readData2,
    output logic [31:0] ex_immediate_32,
    output logic [4:0]  ex_targReg,
    output logic [1:0]  ex_fwdA,
    output logic [1:0]  ex_fwdB,
    output logic [31:0] ex_wb_bypass,
    output logic        stall,
    output logic        ifid_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    logic       load_use;
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;

    // Forwarding source for one operand; register 0 and unread operands never forward.
    function automatic logic [1:0] fwd_sel(
        input logic             src,
        input logic [REG_W-1:0] r,
        input logic             ex_wr,
        input logic             ex_lw,
        input logic [REG_W-1:0] ex_rd,
        input logic             mem_wr,
        input logic [REG_W-1:0] mem_rd,
        input logic             wb_wr,
        input logic [REG_W-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src && (r != REG_W'(0))) begin
            if (ex_wr && !ex_lw && (ex_rd == r))
                sel = FWD_EX;
            else if (mem_wr && (mem_rd == r))
                sel = FWD_MEM;
            else if (wb_wr && (wb_rd == r))
                sel = FWD_WB;
        end
        return sel;
    endfunction

    // Load-use hazard against the instruction currently in EX.
    always_comb begin
        load_use = ex_isLW && ex_if_wr_reg && (ex_targReg != REG_W'(0)) &&
                   ((id_rs_src && (id_rs == ex_targReg)) ||
                    (id_rt_src && (id_rt == ex_targReg)));
    end

    assign stall      = load_use;
    // A taken branch waiting on a stalled load is re-evaluated next cycle.
    assign ifid_flush = id_PCWre && !load_use;

    always_comb begin
        fwd_a_nxt = fwd_sel(id_rs_src, id_rs, ex_if_wr_reg, ex_isLW, ex_targReg,
                            mem_wr_reg, mem_targReg, wb_wr_reg, wb_targReg);
        fwd_b_nxt = fwd_sel(id_rt_src, id_rt, ex_if_wr_reg, ex_isLW, ex_targReg,
                            mem_wr_reg, mem_targReg, wb_wr_reg, wb_targReg);
    end

    // ID/EX pipeline register; a stall inserts an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_if_wr_reg    <= 1'b0;
            ex_isLW         <= 1'b0;
            ex_ALUSrcB      <= 1'b0;
            ex_ALUM2Reg     <= 1'b0;
            ex_DataMemRW    <= 1'b0;
            ex_ALUOp        <= '0;
            ex_readData1    <= '0;
            ex_readData2    <= '0;
            ex_immediate_32 <= '0;
            ex_targReg      <= '0;
            ex_fwdA         <= FWD_RF;
            ex_fwdB         <= FWD_RF;
        end else if (load_use) begin
            ex_if_wr_reg    <= 1'b0;
            ex_isLW         <= 1'b0;
            ex_ALUSrcB      <= 1'b0;
            ex_ALUM2Reg     <= 1'b0;
            ex_DataMemRW    <= 1'b0;
            ex_ALUOp        <= '0;
            ex_readData1    <= '0;
            ex_readData2    <= '0;
            ex_immediate_32 <= '0;
            ex_targReg      <= '0;
            ex_fwdA         <= FWD_RF;
            ex_fwdB         <= FWD_RF;
        end else begin
            ex_if_wr_reg    <= id_if_wr_reg;
            ex_isLW         <= id_isLW;
            ex_ALUSrcB      <= id_ALUSrcB;
            ex_ALUM2Reg     <= id_ALUM2Reg;
            ex_DataMemRW    <= id_DataMemRW;
            ex_ALUOp        <= id_ALUOp;
            ex_readData1    <= id_readData1;
            ex_readData2    <= id_readData2;
            ex_immediate_32 <= id_immediate_32;
            ex_targReg      <= id_targReg;
            ex_fwdA         <= fwd_a_nxt;
            ex_fwdB         <= fwd_b_nxt;
        end
    end

    // Write-back data capture, independent of stalls so code 11 always sees
    // the value written alongside the forwarding decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_wb_bypass <= '0;
        else if (wb_wr_reg)
            ex_wb_bypass <= write_data;
    end

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_use && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ifid_flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = CNT_W'(0);
    assign flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_if_wr_reg, id_isLW, id_ALUSrcB, id_ALUM2Reg, id_DataMemRW;
    logic [2:0]  id_ALUOp;
    logic [31:0] id_readData1, id_readData2, id_immediate_32;
    logic [4:0]  id_rs, id_rt, id_targReg;
    logic        id_rs_src, id_rt_src, id_PCWre;
    logic        mem_wr_reg;
    logic [4:0]  mem_targReg;
    logic        wb_wr_reg;
    logic [4:0]  wb_targReg;
    logic [31:0] write_data;
    logic        ex_if_wr_reg, ex_isLW, ex_ALUSrcB, ex_ALUM2Reg, ex_DataMemRW;
    logic [2:0]  ex_ALUOp;
    logic [31:0] ex_readData1, ex_readData2, ex_immediate_32;
    logic [4:0]  ex_targReg;
    logic [1:0]  ex_fwdA, ex_fwdB;
    logic [31:0] ex_wb_bypass;
    logic        stall, ifid_flush;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

`ifdef ID_EX_PERF_EN
    localparam int FLUSH_N = 65600;
    localparam logic [15:0] EXP_FLUSH = 16'hFFFF;
    localparam logic [15:0] EXP_STALL = 16'd2;
`else
    localparam int FLUSH_N = 8;
    localparam logic [15:0] EXP_FLUSH = 16'd0;
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_if_wr_reg(id_if_wr_reg), .id_isLW(id_isLW), .id_ALUSrcB(id_ALUSrcB),
        .id_ALUM2Reg(id_ALUM2Reg), .id_DataMemRW(id_DataMemRW), .id_ALUOp(id_ALUOp),
        .id_readData1(id_readData1), .id_readData2(id_readData2),
        .id_immediate_32(id_immediate_32), .id_rs(id_rs), .id_rt(id_rt),
        .id_targReg(id_targReg), .id_rs_src(id_rs_src), .id_rt_src(id_rt_src),
        .id_PCWre(id_PCWre), .mem_wr_reg(mem_wr_reg), .mem_targReg(mem_targReg),
        .wb_wr_reg(wb_wr_reg), .wb_targReg(wb_targReg), .write_data(write_data),
        .ex_if_wr_reg(ex_if_wr_reg), .ex_isLW(ex_isLW), .ex_ALUSrcB(ex_ALUSrcB),
        .ex_ALUM2Reg(ex_ALUM2Reg), .ex_DataMemRW(ex_DataMemRW), .ex_ALUOp(ex_ALUOp),
        .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
        .ex_immediate_32(ex_immediate_32), .ex_targReg(ex_targReg),
        .ex_fwdA(ex_fwdA), .ex_fwdB(ex_fwdB), .ex_wb_bypass(ex_wb_bypass),
        .stall(stall), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_if_wr_reg = 0; id_isLW = 0; id_ALUSrcB = 0; id_ALUM2Reg = 0; id_DataMemRW = 0;
        id_ALUOp = 0; id_readData1 = 0; id_readData2 = 0; id_immediate_32 = 0;
        id_rs = 0; id_rt = 0; id_targReg = 0; id_rs_src = 0; id_rt_src = 0; id_PCWre = 0;
    endtask

    // Place "lw $rd" in ID so it enters EX at the next edge.
    task automatic issue_lw(input logic [4:0] rd);
        clear_id();
        id_isLW = 1; id_if_wr_reg = 1; id_ALUM2Reg = 1; id_ALUSrcB = 1; id_targReg = rd;
    endtask

    initial begin
        rst_n = 0;
        clear_id();
        mem_wr_reg = 0; mem_targReg = 0; wb_wr_reg = 0; wb_targReg = 0; write_data = 0;
        #1;
        check("rst_ex_targReg", 32'(ex_targReg), 0);
        check("rst_ex_isLW", 32'(ex_isLW), 0);
        check("rst_ex_fwdA", 32'(ex_fwdA), 0);
        check("rst_bypass", ex_wb_bypass, 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        step(); step();
        @(negedge clk) rst_n = 1;

        // lw $2 enters EX
        issue_lw(5'd2);
        id_readData1 = 32'd100; id_immediate_32 = 32'd8; id_ALUOp = 3'b010;
        step();
        check("lw_ex_isLW", 32'(ex_isLW), 1);
        check("lw_ex_targReg", 32'(ex_targReg), 2);
        check("lw_ex_rd1", ex_readData1, 100);
        check("lw_ex_imm", ex_immediate_32, 8);
        check("lw_ex_aluop", 32'(ex_ALUOp), 2);
        check("lw_ex_alusrcb", 32'(ex_ALUSrcB), 1);

        // add $3,$2,$5 in ID -> load-use stall; taken branch suppressed
        clear_id();
        id_if_wr_reg = 1; id_targReg = 3; id_rs = 2; id_rs_src = 1; id_rt = 5; id_rt_src = 1;
        id_readData1 = 32'h55;
        #1;
        check("lu_stall", 32'(stall), 1);
        check("lu_flush_nobr", 32'(ifid_flush), 0);
        id_PCWre = 1;
        #1;
        check("lu_flush_br", 32'(ifid_flush), 0);
        check("lu_stall_br", 32'(stall), 1);
        id_PCWre = 0;
        step();
        check("bub_wr", 32'(ex_if_wr_reg), 0);
        check("bub_isLW", 32'(ex_isLW), 0);
        check("bub_targ", 32'(ex_targReg), 0);
        check("bub_rd1", ex_readData1, 0);
        check("bub_alusrcb", 32'(ex_ALUSrcB), 0);
        check("bub_fwdA", 32'(ex_fwdA), 0);
        check("bub_stall", 32'(stall), 0);
        // lw now in MEM
        mem_wr_reg = 1; mem_targReg = 2;
        step();
        check("add_fwdA_mem", 32'(ex_fwdA), 2'b10);
        check("add_fwdB", 32'(ex_fwdB), 0);
        check("add_targ", 32'(ex_targReg), 3);
        check("add_rd1", ex_readData1, 32'h55);

        // add $3 in EX; next instruction reads rt=$3 -> EX/MEM forward
        mem_wr_reg = 0; mem_targReg = 0;
        clear_id();
        id_if_wr_reg = 1; id_targReg = 7; id_rt = 3; id_rt_src = 1;
        #1;
        check("exfw_stall", 32'(stall), 0);
        step();
        check("exfw_fwdB", 32'(ex_fwdB), 2'b01);
        check("exfw_fwdA", 32'(ex_fwdA), 0);
        // $7 in EX but rt not read -> 00
        clear_id();
        id_rt = 7; id_rt_src = 0;
        step();
        check("nosrc_fwdB", 32'(ex_fwdB), 0);

        // MEM beats WB; then WB only with bypass capture and hold
        clear_id();
        id_rs = 4; id_rs_src = 1;
        mem_wr_reg = 1; mem_targReg = 4; wb_wr_reg = 1; wb_targReg = 4; write_data = 32'd1234;
        step();
        check("memwb_fwdA", 32'(ex_fwdA), 2'b10);
        check("memwb_bypass", ex_wb_bypass, 1234);
        mem_wr_reg = 0; write_data = 32'hDEADBEEF;
        step();
        check("wb_fwdA", 32'(ex_fwdA), 2'b11);
        check("wb_bypass", ex_wb_bypass, 32'hDEADBEEF);
        wb_wr_reg = 0; write_data = 32'h0;
        step();
        check("hold_fwdA", 32'(ex_fwdA), 0);
        check("hold_bypass", ex_wb_bypass, 32'hDEADBEEF);

        // Register 0 everywhere: never a hazard, never forwarded
        issue_lw(5'd0);
        step();
        check("r0_ex_isLW", 32'(ex_isLW), 1);
        clear_id();
        id_rs_src = 1; id_rt_src = 1;
        mem_wr_reg = 1; mem_targReg = 0; wb_wr_reg = 1; wb_targReg = 0;
        #1;
        check("r0_stall", 32'(stall), 0);
        step();
        check("r0_fwdA", 32'(ex_fwdA), 0);
        check("r0_fwdB", 32'(ex_fwdB), 0);
        mem_wr_reg = 0; wb_wr_reg = 0;

        // Branch with no hazard flushes
        clear_id();
        id_PCWre = 1;
        #1;
        check("br_flush", 32'(ifid_flush), 1);
        check("br_stall", 32'(stall), 0);
        id_PCWre = 0;

        // Reset asserted between edges during a stall
        issue_lw(5'd6);
        step();
        clear_id();
        id_if_wr_reg = 1; id_targReg = 9; id_rs = 6; id_rs_src = 1; id_PCWre = 1;
        #1;
        check("mrs_stall_pre", 32'(stall), 1);
        check("mrs_flush_pre", 32'(ifid_flush), 0);
        #2 rst_n = 0;
        #1;
        check("mrs_isLW", 32'(ex_isLW), 0);
        check("mrs_targ", 32'(ex_targReg), 0);
        check("mrs_wr", 32'(ex_if_wr_reg), 0);
        check("mrs_bypass", ex_wb_bypass, 0);
        check("mrs_stall", 32'(stall), 0);
        check("mrs_flush", 32'(ifid_flush), 1);
        check("mrs_flush_cnt", 32'(flush_cnt), 0);
        id_PCWre = 0;
        @(negedge clk) rst_n = 1;
        step();
        check("post_rst_targ", 32'(ex_targReg), 9);
        check("post_rst_stall", 32'(stall), 0);

        // Two load-use stalls for the counter
        for (int k = 0; k < 2; k++) begin
            issue_lw(5'd6);
            step();
            clear_id();
            id_if_wr_reg = 1; id_targReg = 9; id_rs = 6; id_rs_src = 1;
            step();
            check("cnt_bubble", 32'(ex_if_wr_reg), 0);
            step();
            check("cnt_issue", 32'(ex_targReg), 9);
        end

        // Long run of flushes to drive the flush counter
        clear_id();
        id_PCWre = 1;
        for (int k = 0; k < FLUSH_N; k++) step();
        id_PCWre = 0;
        #1;
        check("flush_cnt", 32'(flush_cnt), 32'(EXP_FLUSH));
        check("stall_cnt", 32'(stall_cnt), 32'(EXP_STALL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order: clk (in, 1, rising-edge clock), then rst_n (in, 1, asynchronous active-low reset).
REQ-002 id_if_wr_reg / ex_if_wr_reg  in/out  1  register-write enable.
REQ-003 id_isLW / ex_isLW  in/out  1  load instruction.
REQ-004 id_ALUSrcB, id_ALUM2Reg, id_DataMemRW / ex_ALUSrcB, ex_ALUM2Reg, ex_DataMemRW  in/out  1 each  datapath controls; DataMemRW=1 means store.
REQ-005 id_ALUOp / ex_ALUOp  in/out  3  ALU operation.
REQ-006 id_readData1, id_readData2, id_immediate_32 / ex_readData1, ex_readData2, ex_immediate_32  in/out  32 each  operands and extended immediate.
REQ-007 id_rs, id_rt, id_targReg / ex_targReg  in/out  5 each  source fields and destination register.
REQ-008 id_rs_src, id_rt_src  in  1 each  instruction reads rs / rt.
REQ-009 id_PCWre  in  1  branch taken in ID.
REQ-010 mem_wr_reg, mem_targReg  in  1, 5  MEM-stage write enable and destination.
REQ-011 wb_wr_reg, wb_targReg, write_data  in  1, 5, 32  write-back port of the register file.
REQ-012 ex_fwdA, ex_fwdB  out  2 each  operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 ex_wb_bypass.
REQ-013 ex_wb_bypass  out  32  captured write_data.
REQ-014 stall  out  1  holds PC and IF/ID; ifid_flush  out  1  squashes IF/ID.
REQ-015 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-016 Define load_use = ex_isLW & ex_if_wr_reg & (ex_targReg!=0) & ((id_rs_src & id_rs==ex_targReg) | (id_rt_src & id_rt==ex_targReg)); stall SHALL equal load_use combinationally.
REQ-017 ifid_flush SHALL equal id_PCWre & ~stall combinationally; a branch depending on a stalled load is re-evaluated next cycle.
REQ-018 On each rising clk with stall=0, all ex_* registers SHALL load their id_* counterparts (1-cycle latency).
REQ-019 On a rising clk with stall=1, the block SHALL load a bubble: every ex_* control, data, field, and fwd output = 0.
REQ-020 ex_fwdA is registered from id_rs with priority: 01 if ex_if_wr_reg & ~ex_isLW & ex_targReg==id_rs; else 10 if mem_wr_reg & mem_targReg==id_rs; else 11 if wb_wr_reg & wb_targReg==id_rs; else 00; ex_fwdB uses the same rule on id_rt.
REQ-021 Register 0 SHALL never match any forwarding or hazard compare; a forwarding code SHALL be 00 when the corresponding *_src input is 0.
REQ-022 ex_wb_bypass SHALL capture write_data every rising clk where wb_wr_reg=1 and otherwise hold its value.
REQ-023 If stall and id_PCWre are both 1, stall SHALL win: ifid_flush=0, and the bubble is inserted.

Reset
REQ-024 While rst_n=0, all registered outputs SHALL be 0 immediately (asynchronous), producing a bubble in EX; stall and ifid_flush follow their combinational equations.
REQ-025 Reset asserted mid-stall SHALL clear ex_isLW, so stall=0 on the first rising clk after release.

Configuration
REQ-026 With ID_EX_PERF_EN defined, stall_cnt and flush_cnt SHALL increment on each rising clk where stall and ifid_flush are 1, respectively.
REQ-027 Each counter SHALL saturate at 16'hFFFF and reset to 0.
REQ-028 Without ID_EX_PERF_EN defined, both counter ports SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-029 lw $2 in EX, id_rs=2, id_rs_src=1 -> stall=1, next edge all ex_* = 0, then the add issues with ex_fwdA=10.
REQ-030 add $3 in EX, next id_rt=3, id_rt_src=1 -> ex_fwdB=01 after edge, stall=0.
REQ-031 mem_targReg=4 and wb_targReg=4, both writing, id_rs=4 -> ex_fwdA=10 (MEM wins); with only WB writing 32'hDEADBEEF -> ex_fwdA=11, ex_wb_bypass=32'hDEADBEEF.
REQ-032 id_PCWre=1 with no hazard -> ifid_flush=1; same cycle with load_use -> ifid_flush=0, stall=1.
REQ-033 Target register 0 in EX/MEM/WB matching id_rs=0 -> fwd=00, stall=0.
REQ-034 rst_n pulled low between edges during a stall -> outputs 0 at once; with ID_EX_PERF_EN, 70000 stalls -> stall_cnt=16'hFFFF.
